exc_ctrl: RTL
=============

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 3: number of cycles flush is held after drain, range 1..15.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 mem_valid  in  1  MEM-stage instruction valid.
REQ-005 mem_pc  in  32  MEM-stage instruction PC.
REQ-006 mem_delayslot  in  1  MEM-stage instruction is in a branch delay slot.
REQ-007 mem_exc_flags  in  8  accumulated exception flags, in COP0 exc_type bit order: 0 break, 1 syscall, 2 reserved inst, 3 overflow, 4 trap, 5 eret, 6 AdEL, 7 AdES.
REQ-008 mem_addr  in  32  MEM-stage data address.
REQ-009 mem_busy  in  1  data-bus transaction outstanding.
REQ-010 exc_en  in  1  COP0 exception/interrupt accept (combinational response to exc_type).
REQ-011 PC_exc  in  32  COP0 target PC, valid when exc_en=1.
REQ-012 exc_type  out  8  exception request to COP0.
REQ-013 victim_inst_addr  out  32  PC reported to COP0.
REQ-014 is_delayslot  out  1  delay-slot flag reported to COP0.
REQ-015 badvaddr  out  32  faulting data address reported to COP0.
REQ-016 flush  out  1  kill IF..MEM contents.
REQ-017 stall  out  1  freeze PC and pipeline registers.
REQ-018 pc_redirect  out  1  one-cycle PC load strobe.
REQ-019 redirect_pc  out  32  PC value to load on pc_redirect.

Function
REQ-020 FSM states IDLE, DRAIN, FLUSH, REDIRECT; a 4-bit counter cnt and a 32-bit register target.
REQ-021 In IDLE: exc_type = mem_valid ? mem_exc_flags : 8'h00; in all other states exc_type = 8'h00, so COP0 sees each request for exactly one cycle.
REQ-022 victim_inst_addr = mem_pc, is_delayslot = mem_delayslot, badvaddr = mem_addr in every state (combinational pass-through).
REQ-023 IDLE with exc_en=1 (exception, eret or interrupt with exc_type=0): target <= PC_exc; next state DRAIN if mem_busy=1, else FLUSH with cnt <= FLUSH_CYCLES-1.
REQ-024 IDLE with exc_en=0: remain IDLE, no flush, even if exc_type is nonzero (COP0 rejection is final; no retry).
REQ-025 DRAIN: stall=1, flush=0; when mem_busy=0 go to FLUSH with cnt <= FLUSH_CYCLES-1; exc_en ignored.
REQ-026 FLUSH: stall=1, flush=1; cnt decrements each cycle; at cnt=0 go to REDIRECT.
REQ-027 REDIRECT: pc_redirect=1, redirect_pc=target, flush=1, stall=0 for exactly one cycle, then IDLE.
REQ-028 redirect_pc = target in all states; pc_redirect=0 outside REDIRECT.
REQ-029 Exception-to-redirect latency with mem_busy=0: FLUSH_CYCLES+1 cycles after the accept cycle.
REQ-030 A new exc_en while in DRAIN/FLUSH/REDIRECT does not alter target or the sequence.
REQ-031 First IDLE cycle after REDIRECT may accept a new exception (back-to-back allowed).

Reset
REQ-032 rst_n=0 forces immediately: state IDLE, cnt 0, target 32'h0, flush 0, stall 0, pc_redirect 0, redirect_pc 32'h0, exc_type 8'h00.
REQ-033 Reset asserted mid-sequence (any state) aborts it; after release the block is in IDLE with no pending redirect.

Verification
REQ-034 Overflow: mem_valid=1, flags=8'h08, mem_pc=32'hBFC0_1004, exc_en=1, PC_exc=32'hBFC0_0380, mem_busy=0 -> exc_type=8'h08 one cycle; flush high 3 cycles; 4th cycle pc_redirect=1, redirect_pc=32'hBFC0_0380.
REQ-035 Store misalign with bus busy: flags=8'h80, mem_addr=32'h8000_0003, mem_busy=1 for 5 cycles -> badvaddr=32'h8000_0003 in accept cycle; stall=1, flush=0 for 5 cycles; then FLUSH, REDIRECT.
REQ-036 Interrupt: mem_valid=1, flags=0, exc_en=1, PC_exc=32'h0000_0030 -> exc_type=0, full sequence, redirect_pc=32'h30.
REQ-037 Rejection: flags=8'h02, exc_en=0 -> stays IDLE, flush/stall/pc_redirect remain 0.
REQ-038 Eret in delay slot then masking: flags=8'h20, mem_delayslot=1, exc_en=1, PC_exc=32'h8000_1000 -> is_delayslot=1; exc_en pulses during FLUSH ignored; redirect_pc=32'h8000_1000.
REQ-039 Reset mid-FLUSH (cnt=1): rst_n low one cycle -> all outputs zero at once, no pc_redirect after release.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception sequencer between the MEM stage and COP0. An accepted request drains
// outstanding bus traffic, flushes IF..MEM for FLUSH_CYCLES cycles and then redirects the PC.
module exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_delayslot,
  input  logic [7:0]  mem_exc_flags,
  input  logic [31:0] mem_addr,
  input  logic        mem_busy,
  input  logic        exc_en,
  input  logic [31:0] PC_exc,
  output logic [7:0]  exc_type,
  output logic [31:0] victim_inst_addr,
  output logic        is_delayslot,
  output logic [31:0] badvaddr,
  output logic        flush,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] target_reg, target_next;
  logic        exc_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      target_reg <= 32'h0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      target_reg <= target_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    target_next = target_reg;
    exc_req     = 1'b0;
    flush       = 1'b0;
    stall       = 1'b0;
    pc_redirect = 1'b0;
    case (state_reg)
      IDLE: begin
        exc_req = mem_valid;
        // exc_en=0 is a final rejection: nothing is retried
        if (exc_en) begin
          target_next = PC_exc;
          if (mem_busy) begin
            state_next = DRAIN;
          end else begin
            state_next = FLUSH;
            cnt_next   = CNT_INIT;
          end
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (!mem_busy) begin
          state_next = FLUSH;
          cnt_next   = CNT_INIT;
        end
      end
      FLUSH: begin
        stall = 1'b1;
        flush = 1'b1;
        if (cnt_reg == 4'd0) begin
          state_next = REDIRECT;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      REDIRECT: begin
        flush       = 1'b1;
        pc_redirect = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request is visible only in IDLE and is forced low while reset is held
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_exc_type
      assign exc_type[gi] = exc_req & rst_n & mem_exc_flags[gi];
    end
  endgenerate

  assign victim_inst_addr = mem_pc;
  assign is_delayslot     = mem_delayslot;
  assign badvaddr         = mem_addr;
  assign redirect_pc      = target_reg;

endmodule
